link_tx_sched: RTL and testbench
================================

Name: link_tx_sched

Overview:
Transmit scheduler for the shared ACK/NAK serial link controller. It arbitrates round-robin among NREQ packet requesters and issues the send strobe (we) to the link controller. It owns the response timer, which generates tim_out, and the retry counter. Each transaction ends with a one-cycle done or fail pulse to the granted requester.

Parameters:
NREQ, 4, number of requesters (2..8)
TW, 8, response-timer width in bits
TIMEOUT, 255, WAIT cycles before tim_out fires; valid range 1..2^TW-1
MAX_RETRY, 3, retransmissions allowed after the first send

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester level request, held until done/fail
busy_n  input  1  1 = link free to accept a send
ack_nak  input  2  link response: 01 ACK, 10 NAK, 00/11 no response
gnt  output  NREQ  one-hot grant, held for the whole transaction
we  output  1  one-cycle send strobe to the link controller
tim_out  output  1  one-cycle response-timeout pulse
done  output  NREQ  one-cycle success pulse on the granted bit
fail  output  NREQ  one-cycle failure pulse on the granted bit
retry_cnt  output  2  retransmissions so far in the current transaction

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; gnt, we, tim_out, done, fail, retry_cnt, timer and rr_ptr all 0.
  - Reset mid-transaction aborts immediately; no done/fail is emitted.
- States: IDLE, SEND, WAIT, RETRY, DONE, FAIL. All outputs are Moore/registered except tim_out, which is decoded in WAIT.
- IDLE:
  - If |req and busy_n, select the first set req bit searching upward from rr_ptr with wrap to 0.
  - Latch the selection into gnt and go to SEND.
  - Otherwise stay in IDLE. ack_nak is ignored.
- SEND:
  - we=1 for exactly one cycle; timer <= 0; next state WAIT.
  - ack_nak is ignored in this cycle.
- WAIT (timer increments each cycle; reads 0 in the first WAIT cycle). Priority, highest first:
  - ACK (01): go to DONE.
  - NAK (10): go to RETRY if retry_cnt<MAX_RETRY, else FAIL.
  - timer==TIMEOUT: tim_out=1 this cycle, then same decision as NAK.
  - Otherwise stay in WAIT.
  - First-possible tim_out occurs TIMEOUT+1 cycles after the we cycle.
  - ACK or NAK arriving in the same cycle as timer==TIMEOUT suppresses tim_out.
- RETRY:
  - retry_cnt increments on entry.
  - Wait for busy_n=1, then go to SEND. gnt is held.
- DONE:
  - done[g]=1 for one cycle.
  - Next cycle: gnt<=0, retry_cnt<=0, rr_ptr<=(g+1) mod NREQ, state IDLE.
- FAIL:
  - fail[g]=1 for one cycle; otherwise identical to DONE, including the rr_ptr advance.
- Requester handling:
  - A granted requester dropping req mid-transaction is ignored; the transaction still completes.
  - New requests arriving during a transaction wait for IDLE.
- Throughput: minimum back-to-back transaction is 4 cycles (IDLE, SEND, WAIT with immediate ACK, DONE). No grant is issued in the DONE/FAIL cycle.
- Timer and counter sizing:
  - The timer never wraps, because WAIT is exited at TIMEOUT.
  - retry_cnt width is fixed at 2; MAX_RETRY must be <=3.

Test Plan:
1. Hold reset_n=0 with req=1111, busy_n=1 -> all outputs 0. Release -> gnt=0001 and we=1 on the 1st edge after release.
2. req=0001, busy_n=1, ACK driven 3 cycles into WAIT -> exactly one we pulse, then done=0001 for 1 cycle. gnt=0 and retry_cnt=0 afterwards.
3. req=0100, NAK, NAK, NAK, then ACK -> 4 we pulses, retry_cnt steps 1,2,3, then done=0100. No fail.
4. req=0010, no response -> tim_out pulses 256 cycles after each of 4 we pulses, then fail=0010. No 5th we.
5. req=1111 held, ACK one cycle into every WAIT -> grant order 0001,0010,0100,1000,0001. Successive done pulses are 4 cycles apart.
6. Two corner cases:
   - busy_n=0 with req=0001 -> stays IDLE, no we. Raising busy_n -> SEND on the next edge.
   - ACK in the same cycle as timer=255 -> done pulse, no tim_out.

Source files
------------

// File: rtl/link_tx_sched.sv
// Round-robin transmit scheduler for the shared ACK/NAK serial link.
// Issues the send strobe and owns the response timer (tim_out) and the retry counter.
module link_tx_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TW        = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            busy_n,
    input  logic [1:0]      ack_nak,
    output logic [NREQ-1:0] gnt,
    output logic            we,
    output logic            tim_out,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] fail,
    output logic [1:0]      retry_cnt
);

    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RETRY,
        S_DONE,
        S_FAIL
    } state_e;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] fail_q;
    logic            we_q;
    logic [1:0]      retry_q;
    logic [TW-1:0]   timer_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [PW-1:0]   gidx_q;

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;
    logic            is_ack;
    logic            is_nak;
    logic            timer_hit;

    // First requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((32'(rr_ptr_q) + i) % NREQ);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign rr_ptr_d  = PW'((32'(gidx_q) + 32'd1) % NREQ);
    assign is_ack    = (ack_nak == 2'b01);
    assign is_nak    = (ack_nak == 2'b10);
    assign timer_hit = (timer_q == TW'(TIMEOUT));
    assign tim_out   = (state_q == S_WAIT) && timer_hit && !is_ack && !is_nak;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            fail_q   <= '0;
            we_q     <= 1'b0;
            retry_q  <= '0;
            timer_q  <= '0;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= '0;
            fail_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (sel_vld && busy_n) begin
                        gnt_q          <= '0;
                        gnt_q[sel_idx] <= 1'b1;
                        gidx_q         <= sel_idx;
                        we_q           <= 1'b1;
                        state_q        <= S_SEND;
                    end
                end
                S_SEND: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (is_ack) begin
                        done_q  <= gnt_q;
                        state_q <= S_DONE;
                    end else if (is_nak || timer_hit) begin
                        if (retry_q < 2'(MAX_RETRY)) begin
                            retry_q <= retry_q + 2'd1;
                            state_q <= S_RETRY;
                        end else begin
                            fail_q  <= gnt_q;
                            state_q <= S_FAIL;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RETRY: begin
                    if (busy_n) begin
                        we_q    <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_DONE, S_FAIL: begin
                    gnt_q    <= '0;
                    retry_q  <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign we        = we_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_link_tx_sched.sv
// Self-checking bench for link_tx_sched: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_link_tx_sched;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned TW        = 8;
    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned MAX_RETRY = 3;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic [NREQ-1:0] req     = '0;
    logic            busy_n  = 1'b0;
    logic [1:0]      ack_nak = 2'b00;
    logic [NREQ-1:0] gnt;
    logic            we;
    logic            tim_out;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] fail;
    logic [1:0]      retry_cnt;

    always #5 clk = ~clk;

    link_tx_sched #(
        .NREQ(NREQ),
        .TW(TW),
        .TIMEOUT(TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .busy_n(busy_n),
        .ack_nak(ack_nak),
        .gnt(gnt),
        .we(we),
        .tim_out(tim_out),
        .done(done),
        .fail(fail),
        .retry_cnt(retry_cnt)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc_n  = 0;

    // Reference model: transaction progress tracked as flags and counters.
    bit              m_active, m_sent_now, m_awaiting, m_retry_wait, m_closing;
    int unsigned     m_age, m_g, m_ptr, m_sends, exp_retry;
    logic [NREQ-1:0] exp_gnt, exp_done, exp_fail;
    logic            exp_we;

    int unsigned     t_we, t_tim, last_we_cyc;
    logic [NREQ-1:0] t_done_or, t_fail_or;
    logic [3:0]      t_retry_seen;
    int unsigned     dcyc[$];
    logic [NREQ-1:0] dgnt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_sent_now = 0; m_awaiting = 0; m_retry_wait = 0; m_closing = 0;
        m_age = 0; m_g = 0; m_ptr = 0; m_sends = 0; exp_retry = 0;
        exp_gnt = '0; exp_done = '0; exp_fail = '0; exp_we = 1'b0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic b, input logic [1:0] an);
        bit ack, nak, found;
        ack = (an == 2'b01);
        nak = (an == 2'b10);
        exp_we = 1'b0; exp_done = '0; exp_fail = '0;
        if (m_closing) begin
            m_closing = 0; m_active = 0; exp_gnt = '0; exp_retry = 0;
            m_ptr = (m_g + 1) % NREQ;
        end else if (!m_active) begin
            if (r != '0 && b) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && r[(m_ptr + k) % NREQ]) begin
                        found = 1;
                        m_g = (m_ptr + k) % NREQ;
                    end
                end
                exp_gnt = '0; exp_gnt[m_g] = 1'b1;
                m_active = 1; exp_we = 1'b1; m_sent_now = 1; m_sends = 1;
            end
        end else if (m_sent_now) begin
            m_sent_now = 0; m_awaiting = 1; m_age = 0;
        end else if (m_awaiting) begin
            if (ack) begin
                m_awaiting = 0; exp_done = exp_gnt; m_closing = 1;
            end else if (nak || m_age == TIMEOUT) begin
                m_awaiting = 0;
                if (exp_retry < MAX_RETRY) begin
                    exp_retry++; m_retry_wait = 1;
                end else begin
                    exp_fail = exp_gnt; m_closing = 1;
                end
            end else begin
                m_age++;
            end
        end else if (m_retry_wait) begin
            if (b) begin
                m_retry_wait = 0; exp_we = 1'b1; m_sent_now = 1; m_sends++;
            end
        end
    endtask

    // One clock: drive at negedge, check tim_out mid-cycle, step model at posedge, check outputs.
    task automatic cyc(input logic [NREQ-1:0] r, input logic b, input logic [1:0] an, input logic rn);
        logic exp_tim;
        @(negedge clk);
        req = r; busy_n = b; ack_nak = an; reset_n = rn;
        if (!rn) model_reset();
        #1;
        exp_tim = m_awaiting && (m_age == TIMEOUT) && (an != 2'b01) && (an != 2'b10);
        chk("tim_out", 32'(tim_out), 32'(exp_tim));
        if (tim_out === 1'b1) begin
            t_tim++;
            chk("tim_gap", cyc_n - last_we_cyc, TIMEOUT + 1);
        end
        @(posedge clk);
        cyc_n++;
        if (rn) model_step(r, b, an);
        #1;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("we", 32'(we), 32'(exp_we));
        chk("done", 32'(done), 32'(exp_done));
        chk("fail", 32'(fail), 32'(exp_fail));
        chk("retry_cnt", 32'(retry_cnt), exp_retry);
        if (we === 1'b1) begin t_we++; last_we_cyc = cyc_n; end
        if (!$isunknown(retry_cnt)) t_retry_seen[retry_cnt] = 1'b1;
        if (!$isunknown(done)) t_done_or |= done;
        if (!$isunknown(fail)) t_fail_or |= fail;
        if (!$isunknown(done) && done != '0) begin dcyc.push_back(cyc_n); dgnt.push_back(done); end
    endtask

    task automatic clr();
        t_we = 0; t_tim = 0; t_done_or = '0; t_fail_or = '0; t_retry_seen = '0;
        dcyc.delete(); dgnt.delete();
    endtask

    task automatic do_reset(input logic [NREQ-1:0] r, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(r, 1'b1, 2'b00, 1'b0);
        cyc(r, 1'b1, 2'b00, 1'b0);
        chk("rst_outs", {26'd0, gnt, we, tim_out}, 32'd0);
        chk("rst_outs2", {22'd0, done, fail, retry_cnt}, 32'd0);
    endtask

    // Runs one transaction; plan holds the response for send 1..4 (2 bits each),
    // applied when the wait has lasted at_age cycles.
    task automatic run_plan(input logic [NREQ-1:0] r, input bit hold, input logic [7:0] plan,
                            input int unsigned at_age, input int unsigned maxc);
        bit started, finished;
        logic [1:0] an;
        started = 0; finished = 0;
        for (int unsigned n = 0; n < maxc && !finished; n++) begin
            an = 2'b00;
            if (m_awaiting && m_age == at_age && m_sends >= 1 && m_sends <= 4)
                an = plan[2*(m_sends-1) +: 2];
            cyc((hold || !started) ? r : '0, 1'b1, an, 1'b1);
            if (m_active) started = 1;
            else if (started) finished = 1;
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL plan_bound: transaction not finished within %0d cycles", maxc);
        end
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        logic [1:0]      an;
        logic [NREQ-1:0] order [5];
        model_reset();
        clr();
        last_we_cyc = 0;

        // Reset with all requesting; first edge after release grants requester 0.
        do_reset(4'hF, 3);
        clr();
        cyc(4'hF, 1'b1, 2'b00, 1'b1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_we", 32'(we), 32'h1);
        run_plan(4'hF, 1'b0, 8'b01, 0, 20);

        // Single ACK three cycles into the wait.
        do_reset('0, 1); clr();
        run_plan(4'b0001, 1'b0, 8'b01, 3, 30);
        chk("t2_we", t_we, 1);
        chk("t2_done", 32'(t_done_or), 32'h1);
        chk("t2_ndone", dcyc.size(), 1);
        chk("t2_gnt_after", 32'(gnt), 32'h0);
        chk("t2_retry_after", 32'(retry_cnt), 32'h0);

        // NAK, NAK, NAK, then ACK.
        do_reset('0, 1); clr();
        run_plan(4'b0100, 1'b0, 8'b01_10_10_10, 0, 40);
        chk("t3_we", t_we, 4);
        chk("t3_retry_seen", 32'(t_retry_seen), 32'hF);
        chk("t3_done", 32'(t_done_or), 32'h4);
        chk("t3_fail", 32'(t_fail_or), 32'h0);

        // No response at all: four timeouts then failure.
        do_reset('0, 1); clr();
        run_plan(4'b0010, 1'b0, 8'b00, 0, 1500);
        chk("t4_we", t_we, 4);
        chk("t4_tim", t_tim, 4);
        chk("t4_fail", 32'(t_fail_or), 32'h2);
        chk("t4_done", 32'(t_done_or), 32'h0);

        // All requesting, immediate ACK: round-robin order at 4-cycle spacing.
        do_reset('0, 1); clr();
        for (int i = 0; i < 5; i++) run_plan(4'hF, 1'b1, 8'b01_01_01_01, 0, 20);
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        chk("t5_ndone", dgnt.size(), 5);
        for (int i = 0; i < 5 && i < dgnt.size(); i++) chk("t5_order", 32'(dgnt[i]), 32'(order[i]));
        for (int i = 1; i < dcyc.size(); i++) chk("t5_spacing", dcyc[i] - dcyc[i-1], 4);

        // Link busy holds off the grant; raising busy_n grants on the next edge.
        do_reset('0, 1); clr();
        for (int i = 0; i < 5; i++) cyc(4'b0001, 1'b0, 2'b00, 1'b1);
        chk("t6a_we", t_we, 0);
        chk("t6a_gnt", 32'(gnt), 32'h0);
        cyc(4'b0001, 1'b1, 2'b00, 1'b1);
        chk("t6a_we_go", 32'(we), 32'h1);
        chk("t6a_gnt_go", 32'(gnt), 32'h1);
        run_plan(4'b0001, 1'b0, 8'b01, 0, 20);

        // ACK coincides with the timeout cycle: done, no tim_out.
        do_reset('0, 1); clr();
        run_plan(4'b0001, 1'b0, 8'b01, TIMEOUT, 400);
        chk("t6b_tim", t_tim, 0);
        chk("t6b_done", 32'(t_done_or), 32'h1);
        chk("t6b_we", t_we, 1);

        // Reset mid-wait aborts without done/fail.
        do_reset('0, 1); clr();
        for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1, 2'b00, 1'b1);
        cyc('0, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 2'b00, 1'b1);
        chk("t7_done", 32'(t_done_or), 32'h0);
        chk("t7_fail", 32'(t_fail_or), 32'h0);
        chk("t7_gnt", 32'(gnt), 32'h0);

        // Randomized traffic, alternating chatty and quiet response phases.
        for (int i = 0; i < 3000; i++) begin
            rq = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            an = 2'b00;
            if ((i / 500) % 2 == 0) begin
                if ($urandom_range(0, 3) == 0) an = 2'($urandom);
            end else begin
                if ($urandom_range(0, 199) == 0) an = 2'($urandom);
            end
            cyc(rq, ($urandom_range(0, 3) != 0), an, ($urandom_range(0, 399) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
